multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Sequences the shared ALU, register file, unified memory and the existing 32-bit/5-bit select muxes and immediate extender over several cycles per instruction.
- Drives every mux select and write enable from a Moore state machine.
- Stalls on a memory-ready handshake.

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/multicycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle MIPS main control FSM.
//   - state_t      : FSM state encoding
//   - OP_*         : instruction opcodes
//   - ALUOP_*, ALUB_*, PCSRC_* : datapath select encodings
//   - decode_target(): DECODE-state dispatch by opcode (FETCH = unsupported)
// Optional feature macro: ZEXT_ORI_EN (adds ori decode).
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        RTYPEEX,
        ALUWB,
        BEQ,
        ADDIEX,
        ADDIWB,
        JUMP,
        ORIEX,
        ORIWB
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Returns the state following DECODE; FETCH marks an unsupported opcode.
    function automatic state_t decode_target(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: decode_target = MEMADR;
            OP_RTYPE:     decode_target = RTYPEEX;
            OP_BEQ:       decode_target = BEQ;
            OP_ADDI:      decode_target = ADDIEX;
            OP_J:         decode_target = JUMP;
`ifdef ZEXT_ORI_EN
            OP_ORI:       decode_target = ORIEX;
`endif
            default:      decode_target = FETCH;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle MIPS datapath.
// Moore machine; outputs decode the current state, with mem_ready gating
// the FETCH loads and op qualifying the DECODE illegal_op pulse.
// Optional feature macro: ZEXT_ORI_EN (ori via ORIEX/ORIWB, aluop = 11).
//
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   op[5:0]         : opcode from the instruction register
//   mem_ready       : memory completes the current access this cycle
//   iord, irwrite, pcwrite, branch, regwrite, memwrite,
//   regdst, memtoreg, alusrca, alusrcb[1:0], pcsrc[1:0], aluop[1:0] :
//                     datapath selects and write enables
//   illegal_op      : one-cycle pulse in DECODE on an unsupported opcode
//
// state   | meaning
// FETCH   | read instruction at PC, PC <= PC+4 when memory ready
// DECODE  | register read, branch target into ALUOut, dispatch on op
// MEMADR  | effective address = A + sign-extended imm
// MEMRD   | load access at ALUOut, held until mem_ready
// MEMWB   | write loaded data to rt
// MEMWR   | store access at ALUOut, held until mem_ready
// RTYPEEX | A funct B
// ALUWB   | write ALUOut to rd
// BEQ     | A - B, PC <= ALUOut when zero
// ADDIEX  | A + sign-extended imm
// ADDIWB  | write ALUOut to rt
// JUMP    | PC <= jump target
// ORIEX   | A | zero-extended imm (ZEXT_ORI_EN only)
// ORIWB   | write ALUOut to rt (ZEXT_ORI_EN only)
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter bit RESET_PC_HOLD = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       regwrite,
    output logic       memwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal_op
);

    state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   state <= mem_ready ? DECODE : FETCH;
                DECODE:  state <= decode_target(op);
                MEMADR: begin
                    if (op == OP_LW)      state <= MEMRD;
                    else if (op == OP_SW) state <= MEMWR;
                    else                  state <= FETCH;
                end
                MEMRD:   state <= mem_ready ? MEMWB : MEMRD;
                MEMWR:   state <= mem_ready ? FETCH : MEMWR;
                RTYPEEX: state <= ALUWB;
                ADDIEX:  state <= ADDIWB;
`ifdef ZEXT_ORI_EN
                ORIEX:   state <= ORIWB;
`endif
                default: state <= FETCH;
            endcase
        end
    end

    // Raw state decode; reset gating is applied afterwards.
    logic       e_iord, e_irwrite, e_pcwrite, e_branch, e_regwrite, e_memwrite;
    logic       e_regdst, e_memtoreg, e_alusrca, e_illegal;
    logic [1:0] e_alusrcb, e_pcsrc, e_aluop;

    always_comb begin
        e_iord     = 1'b0;
        e_irwrite  = 1'b0;
        e_pcwrite  = 1'b0;
        e_branch   = 1'b0;
        e_regwrite = 1'b0;
        e_memwrite = 1'b0;
        e_regdst   = 1'b0;
        e_memtoreg = 1'b0;
        e_alusrca  = 1'b0;
        e_illegal  = 1'b0;
        e_alusrcb  = ALUB_REG;
        e_pcsrc    = PCSRC_ALU;
        e_aluop    = ALUOP_ADD;
        case (state)
            FETCH: begin
                e_alusrcb = ALUB_FOUR;
                e_irwrite = mem_ready;
                e_pcwrite = mem_ready;
            end
            DECODE: begin
                e_alusrcb = ALUB_IMM_SH2;
                e_illegal = (decode_target(op) == FETCH);
            end
            MEMADR: begin
                e_alusrca = 1'b1;
                e_alusrcb = ALUB_IMM;
            end
            MEMRD: e_iord = 1'b1;
            MEMWB: begin
                e_memtoreg = 1'b1;
                e_regwrite = 1'b1;
            end
            MEMWR: begin
                e_iord     = 1'b1;
                e_memwrite = 1'b1;
            end
            RTYPEEX: begin
                e_alusrca = 1'b1;
                e_aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                e_regdst   = 1'b1;
                e_regwrite = 1'b1;
            end
            BEQ: begin
                e_alusrca = 1'b1;
                e_aluop   = ALUOP_SUB;
                e_pcsrc   = PCSRC_ALUOUT;
                e_branch  = 1'b1;
            end
            ADDIEX: begin
                e_alusrca = 1'b1;
                e_alusrcb = ALUB_IMM;
            end
            ADDIWB: e_regwrite = 1'b1;
            JUMP: begin
                e_pcsrc   = PCSRC_JUMP;
                e_pcwrite = 1'b1;
            end
`ifdef ZEXT_ORI_EN
            ORIEX: begin
                e_alusrca = 1'b1;
                e_alusrcb = ALUB_IMM;
                e_aluop   = ALUOP_OR;
            end
            ORIWB: e_regwrite = 1'b1;
`endif
            default: ;
        endcase
    end

    // Reset acts combinationally on the outputs so an instruction
    // interrupted by reset never completes a write in that cycle.
    logic hold_en;
    assign hold_en = reset && RESET_PC_HOLD;

    assign irwrite    = e_irwrite  && !hold_en;
    assign pcwrite    = e_pcwrite  && !hold_en;
    assign branch     = e_branch   && !hold_en;
    assign regwrite   = e_regwrite && !hold_en;
    assign memwrite   = e_memwrite && !hold_en;

    assign iord       = e_iord     && !reset;
    assign regdst     = e_regdst   && !reset;
    assign memtoreg   = e_memtoreg && !reset;
    assign alusrca    = e_alusrca  && !reset;
    assign illegal_op = e_illegal  && !reset;
    assign alusrcb    = reset ? 2'b00 : e_alusrcb;
    assign pcsrc      = reset ? 2'b00 : e_pcsrc;
    assign aluop      = reset ? 2'b00 : e_aluop;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Each stimulus cycle pushes the
// hand-derived expected output vector; a negedge monitor pops and compares.
// Vector layout: {iord, irwrite, pcwrite, branch, regwrite, memwrite,
//                 regdst, memtoreg, alusrca, alusrcb[1:0], pcsrc[1:0],
//                 aluop[1:0], illegal_op}
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b000000;
    logic       mem_ready = 1'b1;
    logic       iord, irwrite, pcwrite, branch, regwrite, memwrite;
    logic       regdst, memtoreg, alusrca, illegal_op;
    logic [1:0] alusrcb, pcsrc, aluop;

    multicycle_ctrl #(.RESET_PC_HOLD(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
        .regwrite(regwrite), .memwrite(memwrite), .regdst(regdst),
        .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .aluop(aluop), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] R_OP = 6'b000000, LW_OP = 6'b100011, SW_OP = 6'b101011;
    localparam logic [5:0] BEQ_OP = 6'b000100, ADDI_OP = 6'b001000, J_OP = 6'b000010;
    localparam logic [5:0] ORI_OP = 6'b001101, BAD_OP = 6'b111111;

    localparam logic [15:0] E_ZERO    = 16'h0000;
    localparam logic [15:0] E_FETCH_R = 16'h6020;
    localparam logic [15:0] E_FETCH_W = 16'h0020;
    localparam logic [15:0] E_DECODE  = 16'h0060;
    localparam logic [15:0] E_DEC_ILL = 16'h0061;
    localparam logic [15:0] E_MEMADR  = 16'h00C0;
    localparam logic [15:0] E_MEMRD   = 16'h8000;
    localparam logic [15:0] E_MEMWB   = 16'h0900;
    localparam logic [15:0] E_MEMWR   = 16'h8400;
    localparam logic [15:0] E_RTYPEEX = 16'h0084;
    localparam logic [15:0] E_ALUWB   = 16'h0A00;
    localparam logic [15:0] E_BEQ     = 16'h108A;
    localparam logic [15:0] E_ADDIEX  = 16'h00C0;
    localparam logic [15:0] E_ADDIWB  = 16'h0800;
    localparam logic [15:0] E_JUMP    = 16'h2010;
    localparam logic [15:0] E_ORIEX   = 16'h00C6;

    logic [15:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    logic [15:0] actual;
    assign actual = {iord, irwrite, pcwrite, branch, regwrite, memwrite,
                     regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop, illegal_op};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [15:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (actual !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", n, actual, e);
            end
        end
    end

    task automatic step(input logic r, input logic [5:0] o, input logic rdy,
                        input logic [15:0] e, input string n);
        @(posedge clk);
        #1;
        reset     = r;
        op        = o;
        mem_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    initial begin
        // reset held 3 cycles
        for (int i = 0; i < 3; i++) step(1'b1, R_OP, 1'b1, E_ZERO, "reset_outputs");

        // R-type, 4 cycles
        step(1'b0, R_OP, 1'b1, E_FETCH_R, "r_fetch");
        step(1'b0, R_OP, 1'b1, E_DECODE,  "r_decode");
        step(1'b0, R_OP, 1'b1, E_RTYPEEX, "r_ex");
        step(1'b0, R_OP, 1'b1, E_ALUWB,   "r_wb");

        // lw: 2 waits in FETCH, 3 waits in MEMRD, 10 cycles total
        step(1'b0, LW_OP, 1'b0, E_FETCH_W, "lw_fetch_wait");
        step(1'b0, LW_OP, 1'b0, E_FETCH_W, "lw_fetch_wait");
        step(1'b0, LW_OP, 1'b1, E_FETCH_R, "lw_fetch");
        step(1'b0, LW_OP, 1'b1, E_DECODE,  "lw_decode");
        step(1'b0, LW_OP, 1'b1, E_MEMADR,  "lw_memadr");
        for (int i = 0; i < 3; i++) step(1'b0, LW_OP, 1'b0, E_MEMRD, "lw_memrd_wait");
        step(1'b0, LW_OP, 1'b1, E_MEMRD,   "lw_memrd");
        step(1'b0, LW_OP, 1'b1, E_MEMWB,   "lw_memwb");

        // sw: 2 waits in MEMWR, memwrite for 3 cycles
        step(1'b0, SW_OP, 1'b1, E_FETCH_R, "sw_fetch");
        step(1'b0, SW_OP, 1'b1, E_DECODE,  "sw_decode");
        step(1'b0, SW_OP, 1'b1, E_MEMADR,  "sw_memadr");
        step(1'b0, SW_OP, 1'b0, E_MEMWR,   "sw_memwr_wait");
        step(1'b0, SW_OP, 1'b0, E_MEMWR,   "sw_memwr_wait");
        step(1'b0, SW_OP, 1'b1, E_MEMWR,   "sw_memwr");

        // beq then j, 3 cycles each
        step(1'b0, BEQ_OP, 1'b1, E_FETCH_R, "beq_fetch");
        step(1'b0, BEQ_OP, 1'b1, E_DECODE,  "beq_decode");
        step(1'b0, BEQ_OP, 1'b1, E_BEQ,     "beq_exec");
        step(1'b0, J_OP,   1'b1, E_FETCH_R, "j_fetch");
        step(1'b0, J_OP,   1'b1, E_DECODE,  "j_decode");
        step(1'b0, J_OP,   1'b1, E_JUMP,    "j_jump");

        // addi, 4 cycles
        step(1'b0, ADDI_OP, 1'b1, E_FETCH_R, "addi_fetch");
        step(1'b0, ADDI_OP, 1'b1, E_DECODE,  "addi_decode");
        step(1'b0, ADDI_OP, 1'b1, E_ADDIEX,  "addi_ex");
        step(1'b0, ADDI_OP, 1'b1, E_ADDIWB,  "addi_wb");

        // unsupported opcode
        step(1'b0, BAD_OP, 1'b1, E_FETCH_R, "bad_fetch");
        step(1'b0, BAD_OP, 1'b1, E_DEC_ILL, "bad_decode");

        // ori: feature-dependent
        step(1'b0, ORI_OP, 1'b1, E_FETCH_R, "ori_fetch");
`ifdef ZEXT_ORI_EN
        step(1'b0, ORI_OP, 1'b1, E_DECODE,  "ori_decode");
        step(1'b0, ORI_OP, 1'b1, E_ORIEX,   "ori_ex");
        step(1'b0, ORI_OP, 1'b1, E_ADDIWB,  "ori_wb");
`else
        step(1'b0, ORI_OP, 1'b1, E_DEC_ILL, "ori_decode_illegal");
`endif

        // reset during MEMWR with memory stalled
        step(1'b0, SW_OP, 1'b1, E_FETCH_R, "rst_sw_fetch");
        step(1'b0, SW_OP, 1'b1, E_DECODE,  "rst_sw_decode");
        step(1'b0, SW_OP, 1'b1, E_MEMADR,  "rst_sw_memadr");
        step(1'b0, SW_OP, 1'b0, E_MEMWR,   "rst_sw_memwr");
        step(1'b1, SW_OP, 1'b0, E_ZERO,    "rst_mid_memwr");
        step(1'b0, R_OP,  1'b1, E_FETCH_R, "rst_after_fetch");
        step(1'b0, R_OP,  1'b1, E_DECODE,  "rst_after_decode");

        begin
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            @(posedge clk);
            if (exp_q.size() > 0) begin
                errors++;
                $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
